// File: rtl/partition_error_monitor_if.sv
// Stimulus/response bundle between the error monitor and the partition pair under evaluation.
// worst_vec is present only when PEM_WORST_VEC_EN is defined.
interface partition_error_monitor_if #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned OUT_W = 4
);
    localparam int unsigned MIS_W = IN_W + 1;
    localparam int unsigned HAM_W = IN_W + $clog2(OUT_W) + 1;
    localparam int unsigned ABS_W = IN_W + OUT_W;

    logic             start;
    logic [IN_W-1:0]  pi_o;
    logic [OUT_W-1:0] exact_po;
    logic [OUT_W-1:0] approx_po;
    logic             busy;
    logic             done;
    logic [MIS_W-1:0] mismatch_cnt;
    logic [HAM_W-1:0] hamming_sum;
    logic [ABS_W-1:0] abs_err_sum;
    logic [OUT_W-1:0] max_abs_err;
`ifdef PEM_WORST_VEC_EN
    logic [IN_W-1:0]  worst_vec;
`endif

    // Monitor side
    modport master (
        input  start, exact_po, approx_po,
        output pi_o, busy, done, mismatch_cnt, hamming_sum, abs_err_sum, max_abs_err
`ifdef PEM_WORST_VEC_EN
        , output worst_vec
`endif
    );

    // Controller / partition side
    modport slave (
        output start, exact_po, approx_po,
        input  pi_o, busy, done, mismatch_cnt, hamming_sum, abs_err_sum, max_abs_err
`ifdef PEM_WORST_VEC_EN
        , input worst_vec
`endif
    );
endinterface

// File: rtl/partition_error_monitor.sv
// Sweeps all input vectors into an exact and an approximate partition and accumulates error metrics.
// Optional worst-vector capture is enabled by defining PEM_WORST_VEC_EN.
module partition_error_monitor #(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    partition_error_monitor_if.master    bus
);
    localparam int unsigned MIS_W = IN_W + 1;
    localparam int unsigned HAM_W = IN_W + $clog2(OUT_W) + 1;
    localparam int unsigned ABS_W = IN_W + OUT_W;
    localparam int unsigned POP_W = $clog2(OUT_W) + 1;
    localparam int unsigned DIF_W = OUT_W + 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IN_W-1:0]  pi_q, pi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MIS_W-1:0] mis_q, mis_d;
    logic [HAM_W-1:0] ham_q, ham_d;
    logic [ABS_W-1:0] abs_q, abs_d;
    logic [OUT_W-1:0] max_q, max_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef PEM_WORST_VEC_EN
    logic [IN_W-1:0]  worst_q, worst_d;
`endif

    logic [OUT_W-1:0] xor_c;
    logic [POP_W-1:0] pop_c;
    logic [DIF_W-1:0] ex_w, ap_w, diff_w;
    logic [OUT_W-1:0] diff_c;

    // Per-vector error terms; only consumed in SAMPLE
    always_comb begin
        xor_c = bus.exact_po ^ bus.approx_po;
        pop_c = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            pop_c = pop_c + POP_W'(xor_c[i]);
        end
        ex_w   = DIF_W'(bus.exact_po);
        ap_w   = DIF_W'(bus.approx_po);
        diff_w = (ex_w >= ap_w) ? (ex_w - ap_w) : (ap_w - ex_w);
        diff_c = OUT_W'(diff_w);
    end

    // Next-state and register-input logic
    always_comb begin
        state_d = state_q;
        pi_d    = pi_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        ham_d   = ham_q;
        abs_d   = abs_q;
        max_d   = max_q;
`ifdef PEM_WORST_VEC_EN
        worst_d = worst_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_DRIVE;
                    pi_d    = '0;
                    cnt_d   = '0;
                    mis_d   = '0;
                    ham_d   = '0;
                    abs_d   = '0;
                    max_d   = '0;
`ifdef PEM_WORST_VEC_EN
                    worst_d = '0;
`endif
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                mis_d = mis_q + MIS_W'(xor_c != '0);
                ham_d = ham_q + HAM_W'(pop_c);
                abs_d = abs_q + ABS_W'(diff_c);
                // Strict compare keeps the first vector that reached the maximum
                if (diff_c > max_q) begin
                    max_d   = diff_c;
`ifdef PEM_WORST_VEC_EN
                    worst_d = pi_q;
`endif
                end
                if (pi_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    pi_d    = pi_q + IN_W'(1);
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pi_q    <= '0;
            cnt_q   <= '0;
            mis_q   <= '0;
            ham_q   <= '0;
            abs_q   <= '0;
            max_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PEM_WORST_VEC_EN
            worst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pi_q    <= pi_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            ham_q   <= ham_d;
            abs_q   <= abs_d;
            max_q   <= max_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PEM_WORST_VEC_EN
            worst_q <= worst_d;
`endif
        end
    end

    assign bus.pi_o         = pi_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mismatch_cnt = mis_q;
    assign bus.hamming_sum  = ham_q;
    assign bus.abs_err_sum  = abs_q;
    assign bus.max_abs_err  = max_q;
`ifdef PEM_WORST_VEC_EN
    assign bus.worst_vec    = worst_q;
`endif

endmodule

// File: tb/tb_partition_error_monitor.sv
// Directed + randomized bench for partition_error_monitor against a vector-list reference model.
// Honours PEM_WORST_VEC_EN when the design is built with it.
module tb_partition_error_monitor;
    localparam int unsigned IN_W  = 7;
    localparam int unsigned OUT_W = 4;
    localparam int NVEC = 1 << IN_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   mode_a = 0;
    int   mode_b = 0;
    logic [OUT_W-1:0] rand_ex [NVEC];
    logic [OUT_W-1:0] rand_ap [NVEC];

    partition_error_monitor_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifa ();
    partition_error_monitor_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifb ();

    partition_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master));
    partition_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.master));

    always #5 clk = ~clk;

    // Partition behaviour per stimulus mode
    function automatic logic [OUT_W-1:0] ex_fn(input int mode, input int v);
        case (mode)
            2:       return OUT_W'(v % 16);
            3:       return rand_ex[v];
            default: return OUT_W'((v / 16) + (v % 16));
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] ap_fn(input int mode, input int v);
        case (mode)
            0:       return ex_fn(mode, v);
            1:       return ex_fn(mode, v) ^ 4'b0001;
            2:       return 4'b0000;
            default: return rand_ap[v];
        endcase
    endfunction

    always_comb begin
        ifa.exact_po  = ex_fn(mode_a, int'(ifa.pi_o));
        ifa.approx_po = ap_fn(mode_a, int'(ifa.pi_o));
        ifb.exact_po  = ex_fn(mode_b, int'(ifb.pi_o));
        ifb.approx_po = ap_fn(mode_b, int'(ifb.pi_o));
    end

    // Field read-back: 0 pi, 1 busy, 2 done, 3 mis, 4 ham, 5 abs, 6 max, 7 worst
    function automatic logic [31:0] rd(input int which, input int field);
        logic [31:0] r;
        r = 32'hdead_beef;
        if (which == 0) begin
            case (field)
                0: r = 32'(ifa.pi_o);
                1: r = 32'(ifa.busy);
                2: r = 32'(ifa.done);
                3: r = 32'(ifa.mismatch_cnt);
                4: r = 32'(ifa.hamming_sum);
                5: r = 32'(ifa.abs_err_sum);
                6: r = 32'(ifa.max_abs_err);
`ifdef PEM_WORST_VEC_EN
                7: r = 32'(ifa.worst_vec);
`endif
                default: r = 32'hdead_beef;
            endcase
        end else begin
            case (field)
                0: r = 32'(ifb.pi_o);
                1: r = 32'(ifb.busy);
                2: r = 32'(ifb.done);
                3: r = 32'(ifb.mismatch_cnt);
                4: r = 32'(ifb.hamming_sum);
                5: r = 32'(ifb.abs_err_sum);
                6: r = 32'(ifb.max_abs_err);
`ifdef PEM_WORST_VEC_EN
                7: r = 32'(ifb.worst_vec);
`endif
                default: r = 32'hdead_beef;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic val);
        if (which == 0) ifa.start = val;
        else            ifb.start = val;
    endtask

    task automatic check_cleared(input string tag, input int which);
        for (int f = 0; f < 7; f++) check($sformatf("%s_f%0d", tag, f), rd(which, f), 32'd0);
    endtask

    // Reference metrics computed straight from the vector list
    task automatic check_results(input string tag, input int which, input int mode);
        int mis, ham, abs_sum, mx, worst, d;
        logic [OUT_W-1:0] e, a;
        mis = 0; ham = 0; abs_sum = 0; mx = 0; worst = 0;
        for (int v = 0; v < NVEC; v++) begin
            e = ex_fn(mode, v);
            a = ap_fn(mode, v);
            if (e != a) mis++;
            ham += $countones(e ^ a);
            d = (int'(e) > int'(a)) ? int'(e) - int'(a) : int'(a) - int'(e);
            abs_sum += d;
            if (d > mx) begin
                mx = d;
                worst = v;
            end
        end
        check({tag, "_mis"}, rd(which, 3), 32'(mis));
        check({tag, "_ham"}, rd(which, 4), 32'(ham));
        check({tag, "_abs"}, rd(which, 5), 32'(abs_sum));
        check({tag, "_max"}, rd(which, 6), 32'(mx));
        check({tag, "_pi"},  rd(which, 0), 32'(NVEC - 1));
`ifdef PEM_WORST_VEC_EN
        check({tag, "_worst"}, rd(which, 7), 32'(worst));
`endif
        if (worst < 0) $display("unreachable");
    endtask

    // Pulse start (called at a negedge) and wait for done; tracks pi_o step timing
    task automatic run_sweep(input string tag, input int which, input int settle,
                             input bit poke, input int exp_cycles);
        int cyc, changes, bad;
        logic [31:0] prev;
        set_start(which, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(which, 1'b0);
        check({tag, "_busy0"}, rd(which, 1), 32'd1);
        check({tag, "_done0"}, rd(which, 2), 32'd0);
        check({tag, "_pi0"},   rd(which, 0), 32'd0);
        cyc = 0; changes = 0; bad = 0; prev = 32'd0;
        while (cyc < 4 * NVEC * (settle + 1)) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (rd(which, 0) !== prev) begin
                if (rd(which, 0) !== prev + 32'd1 || (cyc % (settle + 1)) != 0) bad++;
                changes++;
                prev = rd(which, 0);
            end
            if (rd(which, 2) === 1'b1) break;
            if (poke) set_start(which, 1'($urandom));
        end
        set_start(which, 1'b0);
        check({tag, "_done"},    rd(which, 2), 32'd1);
        check({tag, "_busy"},    rd(which, 1), 32'd0);
        check({tag, "_cycles"},  32'(cyc), 32'(exp_cycles));
        check({tag, "_steps"},   32'(changes), 32'(NVEC - 1));
        check({tag, "_stepbad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        #12;
        check_cleared("rst_a", 0);
        check_cleared("rst_b", 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mode_a = 0;
        run_sweep("exact", 0, 1, 1'b0, 256);
        check_results("exact", 0, 0);

        mode_a = 1;
        run_sweep("xor1", 0, 1, 1'b1, 256);
        check_results("xor1", 0, 1);
        repeat (3) @(negedge clk);
        check("xor1_hold", rd(0, 2), 32'd1);

        // Restart from DONE clears results on the start edge
        mode_a = 0;
        set_start(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0);
        check("restart_done", rd(0, 2), 32'd0);
        check("restart_busy", rd(0, 1), 32'd1);
        check("restart_mis",  rd(0, 3), 32'd0);
        check("restart_abs",  rd(0, 5), 32'd0);
        check("restart_max",  rd(0, 6), 32'd0);
        repeat (300) @(negedge clk);
        check_results("restart", 0, 0);

        mode_a = 2;
        run_sweep("zero", 0, 1, 1'b0, 256);
        check_results("zero", 0, 2);

        // Asynchronous reset in the middle of a sweep
        mode_a = 1;
        set_start(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_cleared("midrst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode_a = 0;
        run_sweep("postrst", 0, 1, 1'b0, 256);
        check_results("postrst", 0, 0);

        mode_a = 3;
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < NVEC; v++) begin
                rand_ex[v] = OUT_W'($urandom);
                rand_ap[v] = ($urandom_range(0, 2) == 0) ? rand_ex[v] : OUT_W'($urandom);
            end
            run_sweep($sformatf("rnd%0d", r), 0, 1, 1'($urandom), 256);
            check_results($sformatf("rnd%0d", r), 0, 3);
        end

        mode_b = 1;
        run_sweep("settle3", 1, 3, 1'b0, 512);
        check_results("settle3", 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/partition_error_monitor.md
Name: partition_error_monitor

Overview:
- Sequential stimulus/checker stage that sits directly upstream and downstream of a synthesized partition (e.g. a 7-in/4-out adder slice).
- Sweeps every input vector 0..2^IN_W-1 into both the exact and the approximate partition, then samples their outputs after a settle delay.
- Accumulates error metrics in hardware, replacing the per-vector display-and-diff flow.
- Results feed the approximation-quality decision for the partition.

Parameters:
- IN_W, 7, partition input width; number of vectors swept = 2^IN_W
- OUT_W, 4, partition output width
- SETTLE, 1, cycles pi_o is held before sampling; legal range 1..15

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle sweep request; sampled only in IDLE
- pi_o  output  IN_W  current input vector, driven to both partitions (bit IN_W-1 = MSB = first partition pin)
- exact_po  input  OUT_W  exact partition output (bit OUT_W-1 = MSB)
- approx_po  input  OUT_W  approximate partition output
- busy  output  1  high during DRIVE/SAMPLE
- done  output  1  high in DONE; results valid
- mismatch_cnt  output  IN_W+1  count of vectors with exact_po != approx_po
- hamming_sum  output  IN_W+$clog2(OUT_W)+1  sum of popcount(exact_po ^ approx_po)
- abs_err_sum  output  IN_W+OUT_W  sum of |exact_po - approx_po| (unsigned values)
- max_abs_err  output  OUT_W  largest |exact_po - approx_po| seen

Behaviour:
- Reset (async assert, sync release): state IDLE; pi_o, all accumulators, max_abs_err, busy, done = 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 -> clear all accumulators and max_abs_err, pi_o=0, settle counter=0, go to DRIVE.
  - Otherwise hold.
- DRIVE:
  - pi_o held stable; settle counter increments each cycle.
  - When the counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE (one cycle): on this edge, register exact_po/approx_po and update:
  - mismatch_cnt += (exact != approx)
  - hamming_sum += popcount(xor)
  - abs_err_sum += |diff|
  - max_abs_err updates only when |diff| is strictly greater (first occurrence wins ties)
  - Then: if pi_o == all-ones, go to DONE; else pi_o += 1, settle counter=0, go to DRIVE.
- DONE:
  - done=1; results and pi_o (all-ones) held.
  - start=1 -> identical to start from IDLE (restart, done drops next cycle).
  - Otherwise remain.
- Arithmetic:
  - Accumulator widths sized so no overflow is possible at the maximum per-vector error.
  - |diff| computed at OUT_W+1 bits, then truncated to OUT_W.
- Latency:
  - Start edge to done high = 2^IN_W * (SETTLE+1) cycles.
  - Defaults: 256 cycles.
- start while busy is ignored; a sweep cannot be aborted except by reset.
- Reset mid-sweep: immediate return to reset values; no partial results retained.
- exact_po/approx_po are don't-care outside SAMPLE.

Optional Feature:
- Macro PEM_WORST_VEC_EN.
- When defined:
  - Extra output worst_vec [IN_W-1:0] (reset 0) captures pi_o at each strict max_abs_err update.
  - Cleared on start.
  - If no error occurs, it stays 0.
- When undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- approx_po tied to exact_po (exact = pi_o[6:4]+pi_o[3:0], truncated to 4 bits), start -> done at cycle 256; mismatch_cnt=0, hamming_sum=0, abs_err_sum=0, max_abs_err=0.
- approx_po = exact_po ^ 4'b0001 -> mismatch_cnt=128, hamming_sum=128, abs_err_sum=128, max_abs_err=1.
- approx_po = 4'b0000, exact_po = pi_o[3:0] -> mismatch_cnt=120, hamming_sum=256, abs_err_sum=960, max_abs_err=15; worst_vec=7'b0001111 with PEM_WORST_VEC_EN.
- rst_n pulsed low at cycle 100 of a sweep -> pi_o, accumulators, busy, done all 0 asynchronously; a fresh start gives results identical to the first test.
- start pulsed repeatedly while busy -> no effect, done still at cycle 256; start in DONE -> restart with accumulators cleared.
- SETTLE=3 with the exact ^ 1 stimulus -> done at cycle 512; pi_o stable for 4 cycles per vector; same results as the second test.
